// File: rtl/cache_fill_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_mem_pkg
// Description : Shared types and constants for the cache fill arbiter:
//               FSM state and fill-owner encodings and the block geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FILL  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    localparam int BLOCK_WORDS       = 8;
    localparam int WORD_BYTES        = 2;
    localparam int WORD_IDX_W        = $clog2(BLOCK_WORDS);
    // Byte-offset bits inside one block: word index plus byte-in-word.
    localparam int BLOCK_OFFSET_BITS = WORD_IDX_W + $clog2(WORD_BYTES);

endpackage
`default_nettype wire

// File: rtl/cache_fill_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : cache_fill_arbiter_if
// Description : Request, memory and fill-port bundle of the cache fill
//               arbiter. master = arbiter side, slave = caches/memory side.
// Revision    : 1.0 - initial release
// ============================================================================
interface cache_fill_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int IDX_W  = 3
);
    logic              i_miss;
    logic [ADDR_W-1:0] i_addr;
    logic              d_miss;
    logic [ADDR_W-1:0] d_addr;
    logic              d_wr;
    logic [ADDR_W-1:0] d_wr_addr;
    logic [15:0]       d_wr_data;

    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata;
    logic              mem_rvalid;

    logic [15:0]       fill_data;
    logic [IDX_W-1:0]  fill_word;
    logic              i_fill_we;
    logic              d_fill_we;
    logic              i_done;
    logic              d_done;
    logic              d_wr_ack;
    logic              busy;

    modport master (
        input  i_miss, i_addr, d_miss, d_addr, d_wr, d_wr_addr, d_wr_data,
        input  mem_rdata, mem_rvalid,
        output mem_en, mem_wr, mem_addr, mem_wdata,
        output fill_data, fill_word, i_fill_we, d_fill_we,
        output i_done, d_done, d_wr_ack, busy
    );

    modport slave (
        output i_miss, i_addr, d_miss, d_addr, d_wr, d_wr_addr, d_wr_data,
        output mem_rdata, mem_rvalid,
        input  mem_en, mem_wr, mem_addr, mem_wdata,
        input  fill_data, fill_word, i_fill_we, d_fill_we,
        input  i_done, d_done, d_wr_ack, busy
    );

endinterface
`default_nettype wire

// File: rtl/cache_fill_arbiter_beat_counter.sv
`default_nettype none
// ============================================================================
// Module      : beat_counter
// Description : Wrapping beat counter with synchronous clear and a flag
//               marking the final beat (all ones).
// Revision    : 1.0 - initial release
// ============================================================================
module beat_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_count,
    output logic             o_last
);

    // Count beats; clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_count <= '0;
        end else if (i_clr) begin
            o_count <= '0;
        end else if (i_inc) begin
            o_count <= o_count + 1'b1;
        end
    end

    assign o_last = &o_count;

endmodule
`default_nettype wire

// File: rtl/cache_fill_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_fill_arbiter
// Description : Shares one pipelined main memory between I-cache fills,
//               D-cache fills and D-cache write-through stores. A fill
//               issues one read per cycle for a whole block and steers each
//               returning word to the owning cache's fill port.
//               Build option: define ARB_RR_EN for round-robin arbitration
//               between the two miss requests (stores keep top priority).
// Revision    : 1.0 - initial release
// ============================================================================
module cache_fill_arbiter #(
    parameter int MEM_LAT     = 4,
    parameter int BLOCK_WORDS = cpu_mem_pkg::BLOCK_WORDS,
    parameter int ADDR_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    cache_fill_arbiter_if.master bus
);
    import cpu_mem_pkg::*;

    localparam int c_IDX_W     = $clog2(BLOCK_WORDS);
    localparam int c_BYTE_BITS = $clog2(WORD_BYTES);
    localparam int c_OFF_BITS  = c_IDX_W + c_BYTE_BITS;
    localparam int c_BLK_W     = ADDR_W - c_OFF_BITS;

    // Reject geometries the address splicing below cannot handle.
    if ((BLOCK_WORDS < 2) || ((BLOCK_WORDS & (BLOCK_WORDS - 1)) != 0) || (MEM_LAT < 1)) begin : g_param_check
        $error("cache_fill_arbiter: BLOCK_WORDS must be a power of two >= 2 and MEM_LAT >= 1");
    end

    state_t             r_state;
    state_t             w_state_nxt;
    owner_t             r_owner;
    owner_t             w_owner_nxt;
    logic [c_BLK_W-1:0] r_base_blk;
    logic [c_BLK_W-1:0] w_base_nxt;
    logic               r_issue_done;

    logic [c_IDX_W-1:0] w_ic;
    logic [c_IDX_W-1:0] w_rc;
    logic               w_ic_last;
    logic               w_rc_last;
    logic               w_ic_inc;
    logic               w_ic_clr;
    logic               w_rc_inc;
    logic               w_rc_clr;

    logic               w_grant_d;
    logic               w_grant_i;
    logic               w_start_fill;
    logic [ADDR_W-1:0]  w_req_addr;

`ifdef ARB_RR_EN
    // 1 = D-cache was granted last, 0 = I-cache (reset value).
    logic r_last_d;

    assign w_grant_d = bus.d_miss & (~bus.i_miss | ~r_last_d);

    // Remember which cache took the most recent fill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_d <= 1'b0;
        end else if (w_start_fill) begin
            r_last_d <= w_grant_d;
        end
    end
`else
    assign w_grant_d = bus.d_miss;
`endif

    assign w_grant_i    = bus.i_miss & ~w_grant_d;
    assign w_start_fill = (r_state == IDLE) & ~bus.d_wr & (w_grant_d | w_grant_i);
    assign w_req_addr   = w_grant_d ? bus.d_addr : bus.i_addr;

    beat_counter #(.WIDTH(c_IDX_W)) u_issue_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_ic_inc),
        .i_clr   (w_ic_clr),
        .o_count (w_ic),
        .o_last  (w_ic_last)
    );

    beat_counter #(.WIDTH(c_IDX_W)) u_recv_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_rc_inc),
        .i_clr   (w_rc_clr),
        .o_count (w_rc),
        .o_last  (w_rc_last)
    );

    // State, owner, block base and the all-reads-issued flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_owner      <= OWN_NONE;
            r_base_blk   <= '0;
            r_issue_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_base_blk <= w_base_nxt;
            if (w_ic_clr) begin
                r_issue_done <= 1'b0;
            end else if (w_ic_inc && w_ic_last) begin
                r_issue_done <= 1'b1;
            end
        end
    end

    // Next-state, memory command, fill steering and handshake pulses.
    always_comb begin
        w_state_nxt   = r_state;
        w_owner_nxt   = r_owner;
        w_base_nxt    = r_base_blk;
        w_ic_inc      = 1'b0;
        w_ic_clr      = 1'b0;
        w_rc_inc      = 1'b0;
        w_rc_clr      = 1'b0;
        bus.mem_en    = 1'b0;
        bus.mem_wr    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.fill_data = '0;
        bus.fill_word = '0;
        bus.i_fill_we = 1'b0;
        bus.d_fill_we = 1'b0;
        bus.i_done    = 1'b0;
        bus.d_done    = 1'b0;
        bus.d_wr_ack  = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.d_wr) begin
                    w_state_nxt = WRITE;
                end else if (w_grant_d || w_grant_i) begin
                    w_state_nxt = FILL;
                    w_owner_nxt = w_grant_d ? OWN_D : OWN_I;
                    w_base_nxt  = w_req_addr[ADDR_W-1:c_OFF_BITS];
                end
            end

            WRITE: begin
                bus.mem_en    = 1'b1;
                bus.mem_wr    = 1'b1;
                bus.mem_addr  = bus.d_wr_addr;
                bus.mem_wdata = bus.d_wr_data;
                bus.d_wr_ack  = 1'b1;
                w_state_nxt   = IDLE;
            end

            FILL: begin
                if (!r_issue_done) begin
                    // Base is block aligned, so base + 2*ic is a splice.
                    bus.mem_en   = 1'b1;
                    bus.mem_addr = {r_base_blk, w_ic, {c_BYTE_BITS{1'b0}}};
                    w_ic_inc     = 1'b1;
                end
                if (bus.mem_rvalid) begin
                    bus.fill_data = bus.mem_rdata;
                    bus.fill_word = w_rc;
                    bus.i_fill_we = (r_owner == OWN_I);
                    bus.d_fill_we = (r_owner == OWN_D);
                    w_rc_inc      = 1'b1;
                    if (w_rc_last) begin
                        w_state_nxt = DONE;
                    end
                end
            end

            DONE: begin
                bus.i_done  = (r_owner == OWN_I);
                bus.d_done  = (r_owner == OWN_D);
                w_ic_clr    = 1'b1;
                w_rc_clr    = 1'b1;
                w_owner_nxt = OWN_NONE;
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.busy = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cache_fill_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_fill_arbiter
// Description : Scoreboard bench for cache_fill_arbiter with a pipelined
//               memory model of fixed read latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_fill_arbiter;

    localparam int MEM_LAT = 4;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
    } mem_exp_t;

    typedef struct packed {
        logic        is_d;
        logic [2:0]  word;
        logic [15:0] data;
    } fill_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cache_fill_arbiter_if #(.ADDR_W(16), .IDX_W(3)) bus ();

    cache_fill_arbiter #(
        .MEM_LAT     (MEM_LAT),
        .BLOCK_WORDS (8),
        .ADDR_W      (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    mem_exp_t    exp_mem[$];
    fill_exp_t   exp_fill[$];
    logic [2:0]  exp_evt[$];

    int evt_cnt[8];
    int evt_cyc[8];
    int fills_seen  = 0;
    int ignored_rv  = 0;

    // Memory model: read data is a fixed function of the address.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [15:0] t;
        t = a * 16'd7;
        return t ^ 16'hC3A5;
    endfunction

    logic [MEM_LAT-1:0]       pipe_v = '0;
    logic [MEM_LAT-1:0][15:0] pipe_d = '0;
    logic                     inj_v  = 1'b0;
    logic [15:0]              inj_d  = 16'h0;

    always @(posedge clk) begin
        pipe_v <= {pipe_v[MEM_LAT-2:0], bus.mem_en & ~bus.mem_wr};
        pipe_d <= {pipe_d[MEM_LAT-2:0], mem_word(bus.mem_addr)};
    end

    assign bus.mem_rvalid = pipe_v[MEM_LAT-1] | inj_v;
    assign bus.mem_rdata  = inj_v ? inj_d : pipe_d[MEM_LAT-1];

    logic [58:0] w_outs;
    assign w_outs = {bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata,
                     bus.fill_data, bus.fill_word, bus.i_fill_we, bus.d_fill_we,
                     bus.i_done, bus.d_done, bus.d_wr_ack, bus.busy};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_fill(input logic is_d, input logic [15:0] addr);
        logic [15:0] base;
        logic [15:0] a;
        base = addr & 16'hFFF0;
        for (int k = 0; k < 8; k++) begin
            a = base + 16'(2 * k);
            exp_mem.push_back('{wr: 1'b0, addr: a, wdata: 16'h0});
            exp_fill.push_back('{is_d: is_d, word: 3'(k), data: mem_word(a)});
        end
        exp_evt.push_back(is_d ? 3'b010 : 3'b100);
    endtask

    task automatic push_write(input logic [15:0] addr, input logic [15:0] data);
        exp_mem.push_back('{wr: 1'b1, addr: addr, wdata: data});
        exp_evt.push_back(3'b001);
    endtask

    // Wait for the given done/ack code, then step past the edge that
    // samples it so the caller can drop the request.
    task automatic wait_evt(input int code, input int budget);
        int start;
        int n;
        start = evt_cnt[code];
        n = 0;
        while (evt_cnt[code] == start && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check($sformatf("evt%0d_seen", code), 64'(evt_cnt[code] - start), 64'd1);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        mem_exp_t   em;
        fill_exp_t  ef;
        logic [2:0] code;
        if (!rst) begin
            if (bus.mem_en) begin
                if (exp_mem.size() == 0) begin
                    check("mem_unexpected", 64'(exp_mem.size()), 64'd1);
                end else begin
                    em = exp_mem.pop_front();
                    check("mem_wr", bus.mem_wr, em.wr);
                    check("mem_addr", bus.mem_addr, em.addr);
                    if (em.wr) check("mem_wdata", bus.mem_wdata, em.wdata);
                end
            end
            if (bus.i_fill_we || bus.d_fill_we) begin
                fills_seen++;
                check("fill_we_both", bus.i_fill_we & bus.d_fill_we, 1'b0);
                if (exp_fill.size() == 0) begin
                    check("fill_unexpected", 64'(exp_fill.size()), 64'd1);
                end else begin
                    ef = exp_fill.pop_front();
                    check("fill_owner", bus.d_fill_we, ef.is_d);
                    check("fill_word", bus.fill_word, ef.word);
                    check("fill_data", bus.fill_data, ef.data);
                end
            end else if (bus.mem_rvalid) begin
                ignored_rv++;
            end
            code = {bus.i_done, bus.d_done, bus.d_wr_ack};
            if (code != 3'b000) begin
                if (exp_evt.size() == 0) begin
                    check("evt_unexpected", 64'(exp_evt.size()), 64'd1);
                end else begin
                    check("evt_code", code, exp_evt.pop_front());
                end
                evt_cnt[code] = evt_cnt[code] + 1;
                evt_cyc[code] = cyc;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int req_cyc;
        int start;
        int n;
        for (int k = 0; k < 8; k++) begin
            evt_cnt[k] = 0;
            evt_cyc[k] = 0;
        end
        bus.i_miss = 0; bus.i_addr = 0; bus.d_miss = 0; bus.d_addr = 0;
        bus.d_wr = 0; bus.d_wr_addr = 0; bus.d_wr_data = 0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", w_outs, 59'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Idle with a stray read return.
        @(posedge clk); #1;
        inj_v = 1'b1; inj_d = 16'h1234;
        @(negedge clk);
        check("idle_fill_we", {bus.i_fill_we, bus.d_fill_we}, 2'b00);
        check("idle_busy", bus.busy, 1'b0);
        check("idle_outputs", w_outs, 59'd0);
        @(posedge clk); #1;
        inj_v = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Single I-cache miss with latency measurement.
        push_fill(1'b0, 16'h1236);
        bus.i_addr = 16'h1236; bus.i_miss = 1'b1;
        req_cyc = cyc;
        wait_evt(4, 40);
        bus.i_miss = 1'b0;
        check("i_latency", 64'(evt_cyc[4] - req_cyc), 64'd13);

        // Simultaneous misses: D block first, then I block.
        repeat (2) @(posedge clk); #1;
        push_fill(1'b1, 16'h0A1C);
        push_fill(1'b0, 16'h77F2);
        bus.d_addr = 16'h0A1C; bus.i_addr = 16'h77F2;
        bus.d_miss = 1'b1; bus.i_miss = 1'b1;
        wait_evt(2, 40);
        bus.d_miss = 1'b0;
        wait_evt(4, 40);
        bus.i_miss = 1'b0;

        // Store plus D miss in the same cycle: store first.
        repeat (2) @(posedge clk); #1;
        push_write(16'h0040, 16'hBEEF);
        push_fill(1'b1, 16'h0452);
        bus.d_wr_addr = 16'h0040; bus.d_wr_data = 16'hBEEF; bus.d_addr = 16'h0452;
        bus.d_wr = 1'b1; bus.d_miss = 1'b1;
        wait_evt(1, 10);
        bus.d_wr = 1'b0;
        wait_evt(2, 40);
        bus.d_miss = 1'b0;
        check("d_after_wr", 64'(evt_cyc[2] - evt_cyc[1]), 64'd14);

        // Reset in the middle of a fill, stale returns, then refill.
        repeat (2) @(posedge clk); #1;
        push_fill(1'b0, 16'h3458);
        bus.i_addr = 16'h3458; bus.i_miss = 1'b1;
        start = fills_seen;
        n = 0;
        while (fills_seen - start < 3 && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        check("fills_before_rst", 64'(fills_seen - start), 64'd3);
        rst = 1'b1;
        bus.i_miss = 1'b0;
        exp_mem.delete();
        exp_fill.delete();
        exp_evt.delete();
        #1;
        check("rst_async_outputs", w_outs, 59'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        start = ignored_rv;
        repeat (10) @(posedge clk);
        #1;
        check("stale_seen", 64'(ignored_rv - start > 0), 64'd1);
        check("post_rst_busy", bus.busy, 1'b0);
        push_fill(1'b0, 16'h3458);
        bus.i_miss = 1'b1;
        wait_evt(4, 40);
        bus.i_miss = 1'b0;

`ifdef ARB_RR_EN
        // Round robin: D served last, so held misses alternate I,D,I,D.
        repeat (2) @(posedge clk); #1;
        push_fill(1'b1, 16'h0100);
        bus.d_addr = 16'h0100; bus.d_miss = 1'b1;
        wait_evt(2, 40);
        bus.d_miss = 1'b0;
        repeat (2) @(posedge clk); #1;
        push_fill(1'b0, 16'h0200);
        push_fill(1'b1, 16'h0302);
        push_fill(1'b0, 16'h0200);
        push_fill(1'b1, 16'h0302);
        bus.i_addr = 16'h0200; bus.d_addr = 16'h0302;
        bus.i_miss = 1'b1; bus.d_miss = 1'b1;
        wait_evt(4, 40);
        wait_evt(2, 40);
        wait_evt(4, 40);
        wait_evt(2, 40);
        bus.i_miss = 1'b0; bus.d_miss = 1'b0;
`endif

        repeat (8) @(posedge clk);
        #1;
        check("left_mem", 64'(exp_mem.size()), 64'd0);
        check("left_fill", 64'(exp_fill.size()), 64'd0);
        check("left_evt", 64'(exp_evt.size()), 64'd0);
        check("final_busy", bus.busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
